// File: rtl/atp_pkg.sv
// Shared types for the automatic payment controller: FSM states and tender type codes.
package atp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COLLECT,
        DONE,
        DISCONNECT
    } state_t;

    localparam logic [1:0] TT_CHEQUE   = 2'd0;
    localparam logic [1:0] TT_DD       = 2'd1;
    localparam logic [1:0] TT_CARD     = 2'd2;
    localparam logic [1:0] TT_CURRENCY = 2'd3;

endpackage

// File: rtl/atp_tender_check.sv
// Combinational tender evaluation: accept/reject decision plus the resulting
// remaining balance and change for an offered tender.
module atp_tender_check
    import atp_pkg::*;
#(
    parameter int unsigned AMT_W     = 16,
    parameter logic [3:0]  MODE_MASK = 4'b1111
) (
    input  logic [1:0]       tender_type,
    input  logic [AMT_W-1:0] tender_amount,
    input  logic [AMT_W-1:0] remaining,
    output logic             accept,
    output logic             covers,
    output logic [AMT_W-1:0] new_remaining,
    output logic [AMT_W-1:0] change
);

    always_comb begin
        covers = (tender_amount >= remaining);
        // Only currency may overpay; every other method must not exceed the balance.
        accept = MODE_MASK[tender_type] && (tender_amount != '0) &&
                 ((tender_type == TT_CURRENCY) || (tender_amount <= remaining));
        new_remaining = covers ? '0 : (remaining - tender_amount);
        change        = covers ? (tender_amount - remaining) : '0;
    end

endmodule

// File: rtl/atp_multi_tender.sv
// Automatic payment controller: a barcode selects a bill which is settled by one
// or more tenders, with refund on cancel, tender limit and inactivity timeout.
module atp_multi_tender
    import atp_pkg::*;
#(
    parameter int unsigned AMT_W       = 16,
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned UNIT_AMT    = 10,
    parameter int unsigned MAX_TENDERS = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [3:0]  MODE_MASK   = 4'b1111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_payment,
    input  logic [CODE_W-1:0] barcode,
    input  logic              cancel,
    input  logic              tender_valid,
    input  logic [1:0]        tender_type,
    input  logic [AMT_W-1:0]  tender_amount,
    output logic              tender_ready,
    output logic              tender_accept,
    output logic              tender_reject,
    output logic [AMT_W-1:0]  remaining_amount,
    output logic [AMT_W-1:0]  change_amount,
    output logic              payment_complete,
    output logic              line_disconnected,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_TENDERS + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] barcode_q, barcode_d;
    logic [AMT_W-1:0]  bill_q, bill_d;
    logic [AMT_W-1:0]  remaining_q, remaining_d;
    logic [AMT_W-1:0]  change_q, change_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  count_inc;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              ready_q, ready_d;
    logic              accept_q, accept_d;
    logic              reject_q, reject_d;
    logic              complete_q, complete_d;
    logic              disc_q, disc_d;
    logic              busy_q, busy_d;

    logic              chk_accept;
    logic              chk_covers;
    logic [AMT_W-1:0]  chk_new_rem;
    logic [AMT_W-1:0]  chk_change;

    atp_tender_check #(
        .AMT_W     (AMT_W),
        .MODE_MASK (MODE_MASK)
    ) u_check (
        .tender_type   (tender_type),
        .tender_amount (tender_amount),
        .remaining     (remaining_q),
        .accept        (chk_accept),
        .covers        (chk_covers),
        .new_remaining (chk_new_rem),
        .change        (chk_change)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        barcode_d   = barcode_q;
        bill_d      = bill_q;
        remaining_d = remaining_q;
        change_d    = change_q;
        count_d     = count_q;
        timer_d     = timer_q;
        accept_d    = 1'b0;
        reject_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_payment) begin
                    barcode_d = barcode;
                    change_d  = '0;
                    count_d   = '0;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (barcode_q == '0) begin
                    state_d = DISCONNECT;
                end else begin
                    bill_d      = AMT_W'(32'(barcode_q) * UNIT_AMT);
                    remaining_d = AMT_W'(32'(barcode_q) * UNIT_AMT);
                    timer_d     = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    reject_d = tender_valid;
                    change_d = bill_q - remaining_q;
                    state_d  = DISCONNECT;
                end else if (tender_valid) begin
                    if (!chk_accept) begin
                        reject_d = 1'b1;
                    end else begin
                        accept_d = 1'b1;
                        timer_d  = '0;
                        if (chk_covers) begin
                            change_d    = chk_change;
                            remaining_d = '0;
                            state_d     = DONE;
                        end else begin
                            remaining_d = chk_new_rem;
                            count_d     = count_inc;
                            // Tender limit reached without settling: refund what was paid.
                            if (32'(count_inc) == MAX_TENDERS) begin
                                change_d = bill_q - chk_new_rem;
                                state_d  = DISCONNECT;
                            end
                        end
                    end
                end else if (32'(timer_q) == TIMEOUT_CYC - 1) begin
                    change_d = bill_q - remaining_q;
                    state_d  = DISCONNECT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE:       state_d = IDLE;
            DISCONNECT: state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        // Outputs are registered alongside the state they belong to.
        ready_d    = (state_d == COLLECT);
        complete_d = (state_d == DONE);
        disc_d     = (state_d == DISCONNECT);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            barcode_q   <= '0;
            bill_q      <= '0;
            remaining_q <= '0;
            change_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            ready_q     <= 1'b0;
            accept_q    <= 1'b0;
            reject_q    <= 1'b0;
            complete_q  <= 1'b0;
            disc_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            barcode_q   <= barcode_d;
            bill_q      <= bill_d;
            remaining_q <= remaining_d;
            change_q    <= change_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            ready_q     <= ready_d;
            accept_q    <= accept_d;
            reject_q    <= reject_d;
            complete_q  <= complete_d;
            disc_q      <= disc_d;
            busy_q      <= busy_d;
        end
    end

    assign tender_ready      = ready_q;
    assign tender_accept     = accept_q;
    assign tender_reject     = reject_q;
    assign remaining_amount  = remaining_q;
    assign change_amount     = change_q;
    assign payment_complete  = complete_q;
    assign line_disconnected = disc_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_atp_multi_tender.sv
// Self-checking bench for atp_multi_tender: vector table, directed corner cases and
// randomized transactions checked against a rule-level reference model.
module tb_atp_multi_tender;
    import atp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_payment;
    logic [3:0]  barcode;
    logic        cancel;
    logic        tender_valid;
    logic [1:0]  tender_type;
    logic [15:0] tender_amount;

    logic        tr_a, ta_a, tj_a, pc_a, ld_a, bs_a;
    logic [15:0] rem_a, chg_a;
    logic        tr_m, ta_m, tj_m, pc_m, ld_m, bs_m;
    logic [15:0] rem_m, chg_m;

    logic        sel_m;
    logic        o_tr, o_ta, o_tj, o_pc, o_ld, o_bs;
    logic [15:0] o_rem, o_chg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    atp_multi_tender dut (
        .clk(clk), .reset(reset), .start_payment(start_payment), .barcode(barcode),
        .cancel(cancel), .tender_valid(tender_valid), .tender_type(tender_type),
        .tender_amount(tender_amount), .tender_ready(tr_a), .tender_accept(ta_a),
        .tender_reject(tj_a), .remaining_amount(rem_a), .change_amount(chg_a),
        .payment_complete(pc_a), .line_disconnected(ld_a), .busy(bs_a)
    );

    atp_multi_tender #(.MODE_MASK(4'b1011)) dut_m (
        .clk(clk), .reset(reset), .start_payment(start_payment), .barcode(barcode),
        .cancel(cancel), .tender_valid(tender_valid), .tender_type(tender_type),
        .tender_amount(tender_amount), .tender_ready(tr_m), .tender_accept(ta_m),
        .tender_reject(tj_m), .remaining_amount(rem_m), .change_amount(chg_m),
        .payment_complete(pc_m), .line_disconnected(ld_m), .busy(bs_m)
    );

    assign o_tr  = sel_m ? tr_m  : tr_a;
    assign o_ta  = sel_m ? ta_m  : ta_a;
    assign o_tj  = sel_m ? tj_m  : tj_a;
    assign o_pc  = sel_m ? pc_m  : pc_a;
    assign o_ld  = sel_m ? ld_m  : ld_a;
    assign o_bs  = sel_m ? bs_m  : bs_a;
    assign o_rem = sel_m ? rem_m : rem_a;
    assign o_chg = sel_m ? chg_m : chg_a;

    typedef struct {
        logic [3:0]  code;
        logic [1:0]  ttype;
        logic [15:0] amt;
        logic        acc;
        logic [15:0] rem;
        logic [15:0] chg;
        logic [15:0] refund;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [3:0] code);
        start_payment = 1'b1;
        barcode       = code;
        step();
        start_payment = 1'b0;
        check("lookup_busy", {31'd0, o_bs}, 1);
        step();
    endtask

    task automatic tender(input logic [1:0] ty, input logic [15:0] amt, input logic canc);
        tender_valid  = 1'b1;
        tender_type   = ty;
        tender_amount = amt;
        cancel        = canc;
        step();
        tender_valid  = 1'b0;
        cancel        = 1'b0;
    endtask

    initial begin
        int n, code, bill, owed, nt, idle, chg, act, ty, am;
        bit live, ea, ej, ec, ed;

        vecs[0] = '{4'd3,  TT_CHEQUE,   16'd30,    1'b1, 16'd0,  16'd0,     16'd0};
        vecs[1] = '{4'd3,  TT_CHEQUE,   16'd31,    1'b0, 16'd30, 16'd0,     16'd0};
        vecs[2] = '{4'd3,  TT_CURRENCY, 16'd35,    1'b1, 16'd0,  16'd5,     16'd0};
        vecs[3] = '{4'd4,  TT_CARD,     16'd15,    1'b1, 16'd25, 16'd0,     16'd15};
        vecs[4] = '{4'd2,  TT_DD,       16'd0,     1'b0, 16'd20, 16'd0,     16'd0};
        vecs[5] = '{4'd15, TT_CARD,     16'd150,   1'b1, 16'd0,  16'd0,     16'd0};
        vecs[6] = '{4'd1,  TT_CURRENCY, 16'd65535, 1'b1, 16'd0,  16'd65525, 16'd0};
        vecs[7] = '{4'd9,  TT_DD,       16'd89,    1'b1, 16'd1,  16'd0,     16'd89};
        vecs[8] = '{4'd8,  TT_CURRENCY, 16'd7,     1'b1, 16'd73, 16'd0,     16'd7};
        vecs[9] = '{4'd6,  TT_CARD,     16'd61,    1'b0, 16'd60, 16'd0,     16'd0};

        sel_m = 1'b0;
        reset = 1'b1;
        start_payment = 1'b0;
        barcode = '0;
        cancel = 1'b0;
        tender_valid = 1'b0;
        tender_type = '0;
        tender_amount = '0;
        step();
        step();
        check("reset_outputs", {o_tr, o_ta, o_tj, o_pc, o_ld, o_bs, o_rem, o_chg}, 0);
        reset = 1'b0;
        step();

        // Mask 1011 instance: card refused, then the tender limit ends the sale.
        sel_m = 1'b1;
        start_txn(4'd7);
        check("mask_ready", {31'd0, o_tr}, 1);
        tender(TT_CARD, 16'd10, 1'b0);
        check("mask_card_rej", {o_ta, o_tj, o_ld}, 3'b010);
        check("mask_card_rem", o_rem, 70);
        for (int i = 1; i <= 3; i++) begin
            tender(TT_CHEQUE, 16'd10, 1'b0);
            check("mask_chq_acc", {o_ta, o_tj, o_ld, o_pc}, 4'b1000);
            check("mask_chq_rem", o_rem, 32'(70 - 10 * i));
        end
        tender(TT_CHEQUE, 16'd10, 1'b0);
        check("limit_pulses", {o_ta, o_tj, o_ld, o_pc}, 4'b1010);
        check("limit_refund", o_chg, 40);
        check("limit_rem", o_rem, 30);
        step();
        check("limit_idle", {o_ld, o_bs}, 0);
        sel_m = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            start_txn(vecs[i].code);
            check("vec_ready", {31'd0, o_tr}, 1);
            tender(vecs[i].ttype, vecs[i].amt, 1'b0);
            check("vec_resp", {o_ta, o_tj}, {vecs[i].acc, !vecs[i].acc});
            check("vec_rem", o_rem, vecs[i].rem);
            check("vec_chg", o_chg, vecs[i].chg);
            check("vec_done", {31'd0, o_pc}, {31'd0, vecs[i].acc && vecs[i].rem == 0});
            if (!(vecs[i].acc && vecs[i].rem == 0)) begin
                cancel = 1'b1;
                step();
                cancel = 1'b0;
                check("vec_cancel", {o_ld, o_tj, o_ta}, 3'b100);
                check("vec_refund", o_chg, vecs[i].refund);
            end
            step();
            check("vec_idle", {o_pc, o_ld, o_bs, o_tr}, 0);
        end

        // Two-tender settlement with currency change.
        start_txn(4'd4);
        tender(TT_CARD, 16'd15, 1'b0);
        check("split_rem", o_rem, 25);
        tender(TT_CURRENCY, 16'd50, 1'b0);
        check("split_done", {o_ta, o_pc}, 2'b11);
        check("split_chg", o_chg, 25);
        step();
        check("split_hold", {o_pc, o_rem, o_chg}, 25);

        // Oversized cheque refused, then exact currency.
        start_txn(4'd2);
        check("start_clears_chg", o_chg, 0);
        tender(TT_CHEQUE, 16'd50, 1'b0);
        check("over_rej", {o_ta, o_tj, o_rem}, {2'b01, 16'd20});
        tender(TT_CURRENCY, 16'd20, 1'b0);
        check("exact_cur", {o_pc, o_chg}, {1'b1, 16'd0});
        step();

        // Inactivity timeout.
        start_txn(4'd5);
        n = 0;
        while (!o_ld && n < 100) begin
            step();
            n++;
        end
        check("timeout_cycles", n, 64);
        check("timeout_chg", o_chg, 0);
        check("timeout_rem", o_rem, 50);
        step();

        // Tender on the expiry cycle wins over the timeout.
        start_txn(4'd5);
        for (int i = 0; i < 63; i++) step();
        check("pre_expiry", {31'd0, o_ld}, 0);
        tender(TT_CHEQUE, 16'd10, 1'b0);
        check("expiry_tender", {o_ta, o_ld, o_rem}, {2'b10, 16'd40});
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("expiry_refund", {o_ld, o_chg}, {1'b1, 16'd10});
        step();

        // Invalid barcode disconnects straight from lookup.
        start_txn(4'd0);
        check("bc0_disc", {o_ld, o_tr, o_bs}, 3'b101);
        step();
        check("bc0_pulse", {o_ld, o_bs}, 0);

        // Cancel together with a tender: reject plus refund.
        start_txn(4'd6);
        tender(TT_DD, 16'd20, 1'b0);
        check("cancel_pre", o_rem, 40);
        tender(TT_CARD, 16'd5, 1'b1);
        check("cancel_pulses", {o_ta, o_tj, o_ld}, 3'b011);
        check("cancel_refund", o_chg, 20);
        step();

        // Reset mid-transaction: silent discard.
        start_txn(4'd5);
        tender(TT_CHEQUE, 16'd10, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset", {o_tr, o_ta, o_tj, o_pc, o_ld, o_bs, o_rem}, 0);
        step();
        check("mid_reset_quiet", {o_pc, o_ld, o_bs}, 0);

        for (int t = 0; t < 40; t++) begin
            code = $urandom_range(1, 15);
            bill = code * 10;
            owed = bill;
            nt = 0;
            idle = 0;
            chg = 0;
            live = 1'b1;
            start_txn(code[3:0]);
            for (int c = 0; c < 300 && live; c++) begin
                act = $urandom_range(0, 19);
                ty = $urandom_range(0, 3);
                am = $urandom_range(0, bill + 15);
                if ($urandom_range(0, 3) == 0) am = owed;
                ea = 0; ej = 0; ec = 0; ed = 0;
                start_payment = $urandom_range(0, 1);
                barcode = 4'($urandom);
                cancel = (act == 0);
                tender_valid = (act >= 8) || (act == 0 && $urandom_range(0, 1) == 1);
                tender_type = ty[1:0];
                tender_amount = am[15:0];
                if (cancel) begin
                    ej = tender_valid; ed = 1; chg = bill - owed; live = 0;
                end else if (tender_valid) begin
                    if (am == 0 || (am > owed && ty != 3)) begin
                        ej = 1;
                    end else begin
                        ea = 1;
                        idle = 0;
                        if (am >= owed) begin
                            chg = am - owed; owed = 0; ec = 1; live = 0;
                        end else begin
                            owed -= am;
                            nt++;
                            if (nt == 4) begin
                                ed = 1; chg = bill - owed; live = 0;
                            end
                        end
                    end
                end else if (idle == 63) begin
                    ed = 1; chg = bill - owed; live = 0;
                end else begin
                    idle++;
                end
                step();
                start_payment = 1'b0;
                cancel = 1'b0;
                tender_valid = 1'b0;
                check("rnd_pulses", {o_ta, o_tj, o_pc, o_ld}, {ea, ej, ec, ed});
                check("rnd_rem", o_rem, owed);
                check("rnd_chg", o_chg, chg);
            end
            check("rnd_ended", {31'd0, live}, 0);
            step();
            check("rnd_idle", {o_bs, o_pc, o_ld}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
